// File: rtl/player_controller.sv
// Player sequencer: gates arrows, turns space presses into rope fires, runs hit/blink/respawn and lives.
// Latency: moves combinational; fireShot, playerResetN, lives, playerVisible, gameOver registered (1 clk).
// Backpressure: fire requests are dropped while a rope is in flight or the cooldown is running.
module player_controller #(
   parameter int INITIAL_LIVES = 3,
   parameter int HIT_FRAMES    = 60,
   parameter int BLINK_FRAMES  = 8,
   parameter int FIRE_COOLDOWN = 6
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       rightArrow,
   input  logic       leftArrow,
   input  logic       spaceBar,
   input  logic       ballCollision,
   input  logic       shotActive,
   output logic       rightMove,
   output logic       leftMove,
   output logic       fireShot,
   output logic       playerResetN,
   output logic       playerVisible,
   output logic [2:0] lives,
   output logic       gameOver
);

   localparam logic [2:0] LIVES_INIT = 3'(INITIAL_LIVES);
   localparam logic [7:0] HIT_LOAD   = 8'(HIT_FRAMES);
   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
   localparam logic [7:0] CD_LOAD    = 8'(FIRE_COOLDOWN);

   typedef enum logic [2:0] {IDLE, RESPAWN, PLAY, HIT, GAME_OVER} state_t;

   state_t     state, nextState;
   logic       spacePrev;
   logic       spaceRise;
   logic       fireReq;
   logic       hitDone;
   logic [7:0] hitCnt;
   logic [7:0] blinkCnt;
   logic [7:0] cooldown;

   assign spaceRise = spaceBar & ~spacePrev;
   // Collision wins over a simultaneous fire request.
   assign fireReq   = (state == PLAY) & spaceRise & ~shotActive & (cooldown == 8'd0) & ~ballCollision;
   assign hitDone   = (state == HIT) & startOfFrame & (hitCnt <= 8'd1);
   assign rightMove = (state == PLAY) & rightArrow;
   assign leftMove  = (state == PLAY) & leftArrow;

   // State register.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= nextState;
   end

   // Next-state decode; collisions only matter in PLAY.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:      if (spaceRise) nextState = RESPAWN;
         RESPAWN:   nextState = PLAY;
         PLAY:      if (ballCollision) nextState = (lives <= 3'd1) ? GAME_OVER : HIT;
         HIT:       if (hitDone) nextState = RESPAWN;
         GAME_OVER: if (spaceRise) nextState = IDLE;
         default:   nextState = IDLE;
      endcase
   end

   // Registered pulses and status flags, all derived from the state being entered.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         spacePrev    <= 1'b1;
         fireShot     <= 1'b0;
         playerResetN <= 1'b1;
         gameOver     <= 1'b0;
      end else begin
         spacePrev    <= spaceBar;
         fireShot     <= fireReq;
         playerResetN <= (nextState != RESPAWN);
         gameOver     <= (nextState == GAME_OVER);
      end
   end

   // Lives: reloaded in IDLE and when leaving GAME_OVER, decremented on a PLAY collision.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         lives <= LIVES_INIT;
      end else if (state == IDLE || (state == GAME_OVER && spaceRise)) begin
         lives <= LIVES_INIT;
      end else if (state == PLAY && ballCollision && lives != 3'd0) begin
         lives <= lives - 3'd1;
      end
   end

   // Fire cooldown in frames; a fresh load takes priority over the frame decrement.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)                                 cooldown <= 8'd0;
      else if (state == RESPAWN)                   cooldown <= 8'd0;
      else if (fireReq)                            cooldown <= CD_LOAD;
      else if (startOfFrame && cooldown != 8'd0)   cooldown <= cooldown - 8'd1;
   end

   // Hit timer and blink generator; sprite is visible everywhere except while blinking off in HIT.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         hitCnt        <= 8'd0;
         blinkCnt      <= 8'd0;
         playerVisible <= 1'b1;
      end else if (state == PLAY && ballCollision && lives > 3'd1) begin
         hitCnt        <= HIT_LOAD;
         blinkCnt      <= 8'd0;
         playerVisible <= 1'b0;
      end else if (state == HIT) begin
         if (startOfFrame) begin
            if (hitCnt <= 8'd1) begin
               hitCnt        <= 8'd0;
               blinkCnt      <= 8'd0;
               playerVisible <= 1'b1;
            end else begin
               hitCnt <= hitCnt - 8'd1;
               if (blinkCnt >= BLINK_LAST) begin
                  blinkCnt      <= 8'd0;
                  playerVisible <= ~playerVisible;
               end else begin
                  blinkCnt <= blinkCnt + 8'd1;
               end
            end
         end
      end else begin
         playerVisible <= 1'b1;
      end
   end

endmodule

// File: doc/player_controller.md
# player_controller

Game-level sequencer for the player sprite in the Bubble Trouble datapath. Sits between the keyboard decoder and the player-movement block. Gates arrow keys into the movement block, turns space-bar presses into single rope-fire requests, and tracks lives. On a ball collision it runs the hit/blink/respawn sequence and enters game-over when lives run out.

## Interface
Parameters:
- INITIAL_LIVES, 3, lives loaded at game start; legal 1..7
- HIT_FRAMES, 60, frames spent in HIT (invulnerable, frozen) after a collision; legal 1..255
- BLINK_FRAMES, 8, frames per visibility toggle during HIT; legal 1..255
- FIRE_COOLDOWN, 6, frames after a fire before the next fire is accepted; legal 0..255

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-clk pulse per video frame
- rightArrow, leftArrow  in  1 each  key levels, clk-synchronous
- spaceBar  in  1  key level, clk-synchronous
- ballCollision  in  1  level, high while player overlaps any ball
- shotActive  in  1  level from rope block, high while a rope is in flight
- rightMove, leftMove  out  1 each  gated arrows to the movement block
- fireShot  out  1  one-clk pulse requesting a rope launch
- playerResetN  out  1  active-low, one-clk pulse that re-homes the movement block
- playerVisible  out  1  sprite draw enable
- lives  out  3  remaining lives
- gameOver  out  1  high in GAME_OVER

## Operation
- States: IDLE, RESPAWN, PLAY, HIT, GAME_OVER.
- spaceRise = spaceBar & ~spacePrev. spacePrev is registered every clk and resets to 1, so a key held through reset gives no edge.
- IDLE:
  - lives = INITIAL_LIVES; moves gated 0; visible 1.
  - spaceRise -> RESPAWN.
- RESPAWN:
  - Lasts exactly 1 clk with playerResetN = 0.
  - Clears the cooldown counter; then -> PLAY.
- PLAY:
  - rightMove = rightArrow and leftMove = leftArrow, combinational pass-through. Both pressed pass as both; the movement block resolves it.
  - Fire: spaceRise & ~shotActive & cooldown==0 -> fireShot = 1 next clk, and cooldown loads FIRE_COOLDOWN.
  - cooldown decrements on startOfFrame while nonzero.
- PLAY collision: ballCollision=1 -> lives <= lives-1 on the same edge.
  - If lives was 1 -> GAME_OVER.
  - Otherwise -> HIT, with hitCnt = HIT_FRAMES, blinkCnt = 0, playerVisible = 0.
- Collision priority: collision beats a fire request in the same cycle; no fireShot is issued.
- HIT:
  - Moves gated 0; spaceRise ignored; ballCollision ignored.
  - On startOfFrame: hitCnt decrements; blinkCnt increments. When blinkCnt reaches BLINK_FRAMES-1, it wraps to 0 and playerVisible toggles.
  - hitCnt reaching 0 -> RESPAWN with playerVisible forced 1.
- GAME_OVER:
  - gameOver = 1, lives = 0, moves gated 0, visible 1.
  - spaceRise -> IDLE, which reloads lives.
- ballCollision is ignored outside PLAY.
- lives never underflows below 0.

## Timing
- Reset values (asynchronous): state = IDLE, lives = INITIAL_LIVES, fireShot = 0, playerResetN = 1, playerVisible = 1, gameOver = 0, all counters 0, spacePrev = 1.
- Reset asserted mid-sequence (HIT, GAME_OVER, etc.) returns to IDLE immediately. No pending fireShot or playerResetN pulse survives.
- Latency:
  - spaceBar rise -> fireShot high: 1 clk (registered); fireShot width is exactly 1 clk.
  - ballCollision -> state HIT and lives updated: 1 clk.
  - IDLE spaceRise -> playerResetN low for the following clk; PLAY starts 1 clk later.
- rightMove and leftMove respond combinationally to the arrows and state; there is no extra delay.
- HIT duration: exactly HIT_FRAMES startOfFrame pulses, then 1 clk of RESPAWN.
- A startOfFrame coinciding with the entry edge into HIT is not counted.
- gameOver, lives and playerVisible are registered outputs.

## Test plan
- Reset with spaceBar held high -> no fireShot, state IDLE, lives=3. Release, press -> playerResetN low for exactly 1 clk, then PLAY.
- PLAY, rightArrow=1 -> rightMove=1 on the same cycle. Assert ballCollision -> next clk lives=2, rightMove=0, playerVisible=0.
- HIT with defaults:
  - Visible toggles after every 8 frames.
  - Space presses produce no fireShot.
  - After 60 frames, one playerResetN pulse, then PLAY with visible=1.
- Fire rules:
  - Space press with shotActive=0 -> single 1-clk fireShot.
  - Second press 3 frames later -> none (cooldown).
  - Press with shotActive=1 after 6 frames -> none.
  - Press after shotActive drops -> fireShot.
- Three collisions from lives=3 -> lives 2, 1, then 0 with gameOver=1 one clk after the third. Space press -> IDLE with lives=3.
- Edge cases:
  - ballCollision and spaceRise in the same PLAY cycle -> HIT, no fireShot.
  - resetN pulsed low mid-HIT -> IDLE, lives=3, visible=1.
